// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO result pair.
// Optional MULDIV_EARLY_TERM_EN: multiply RUN ends once remaining multiplier bits are zero.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// PREP  | operand magnitudes and result signs; divide-by-zero shortcut
// RUN   | one multiplier/quotient bit per cycle
// FIX   | sign correction, results registered into hi_out/lo_out
// DONE  | done pulse; start here chains straight into PREP
module mips_cpu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_enable,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out,
    output logic            div_zero
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     a_q, b_q;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0]     mplier_q;
    logic [XLEN-1:0]     rem_q;
    logic                neg_res_q, neg_rem_q;

    logic                is_div, is_signed, b_zero, run_last;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       div_shift, div_diff;
    logic [2*XLEN-1:0]   prod_fix;

    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign b_zero    = (b_q == '0);
    assign mag_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
    assign mag_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

    // Restoring step: remainder stays below the divisor, so XLEN+1 bits hold the trial subtract.
    assign div_shift = {rem_q, acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q[XLEN-1:0]};
    assign prod_fix  = neg_res_q ? -acc_q : acc_q;

`ifdef MULDIV_EARLY_TERM_EN
    assign run_last = (cnt_q == '0) || (!is_div && (mplier_q[XLEN-1:1] == '0));
`else
    assign run_last = (cnt_q == '0);
`endif

    assign busy = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else if (clk_enable) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = (is_div && b_zero) ? S_DONE : S_RUN;
            S_RUN:   if (run_last) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = start ? S_PREP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_out    <= '0;
            lo_out    <= '0;
            div_zero  <= 1'b0;
        end else if (clk_enable) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_q     <= op;
                        a_q      <= op_a;
                        b_q      <= op_b;
                        div_zero <= 1'b0;
                    end
                end
                S_PREP: begin
                    neg_res_q <= is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
                    neg_rem_q <= is_signed && a_q[XLEN-1];
                    cnt_q     <= CW'(XLEN - 1);
                    rem_q     <= '0;
                    if (is_div) begin
                        acc_q   <= {{XLEN{1'b0}}, mag_a};
                        mcand_q <= {{XLEN{1'b0}}, mag_b};
                    end else begin
                        acc_q    <= '0;
                        mcand_q  <= {{XLEN{1'b0}}, mag_a};
                        mplier_q <= mag_b;
                    end
                    if (is_div && b_zero) begin
                        hi_out   <= a_q;
                        lo_out   <= '1;
                        div_zero <= 1'b1;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (is_div) begin
                        // acc_q[XLEN-1:0] shifts dividend bits out the top and quotient bits in the bottom
                        if (!div_diff[XLEN]) begin
                            rem_q <= div_diff[XLEN-1:0];
                            acc_q <= {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                        end else begin
                            rem_q <= div_shift[XLEN-1:0];
                            acc_q <= {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        lo_out <= neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                        hi_out <= neg_rem_q ? -rem_q : rem_q;
                    end else begin
                        hi_out <= prod_fix[2*XLEN-1:XLEN];
                        lo_out <= prod_fix[XLEN-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Self-checking bench for mips_cpu_muldiv: arithmetic reference model plus directed vectors.
module tb_mips_cpu_muldiv;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi_out, lo_out;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    mips_cpu_muldiv #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
        .op(op), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the ISA definition.
    function automatic void model_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] h, output logic [31:0] l, output bit dz);
        longint      sa, sb, sp;
        logic [63:0] up;
        dz = 1'b0;
        case (o)
            2'd0: begin
                sa = $signed(a); sb = $signed(b); sp = sa * sb;
                h = sp[63:32]; l = sp[31:0];
            end
            2'd1: begin
                up = {32'd0, a} * {32'd0, b};
                h = up[63:32]; l = up[31:0];
            end
            default: begin
                if (b == 0) begin
                    h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
                end else if (o == 2'd2) begin
                    sa = $signed(a); sb = $signed(b);
                    sp = sa / sb; l = sp[31:0];
                    sp = sa % sb; h = sp[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    // Cycles from the cycle start is raised to the cycle done is high.
    function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] m;
        int          top;
        if (o[1]) return (b == 0) ? 2 : 35;
`ifdef MULDIV_EARLY_TERM_EN
        m = (!o[0] && b[31]) ? -b : b;
        top = 0;
        for (int i = 0; i < 32; i++) if (m[i]) top = i;
        return 4 + top;
`else
        m = b;
        top = 0;
        return 35 + top * int'(m == 32'hx);
`endif
    endfunction

    int          busy_left = 0;
    bit          m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0, m_accept;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_left = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
        end else if (clk_enable) begin
            m_accept = start && (busy_left == 0);
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    m_done = 1'b1; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz;
                end
            end else begin
                m_done = 1'b0;
            end
            if (m_accept) begin
                model_calc(op, op_a, op_b, p_hi, p_lo, p_dz);
                busy_left = model_lat(op, op_b) - 1;
                m_dz = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy", 64'(busy), 64'(busy_left > 0));
        chk("cyc_done", 64'(done), 64'(m_done));
        chk("cyc_hi", 64'(hi_out), 64'(m_hi));
        chk("cyc_lo", 64'(lo_out), 64'(m_lo));
        chk("cyc_dz", 64'(div_zero), 64'(m_dz));
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a, b, h, l;
        bit          dz;
        int          lat;
        bit          b2b;
    } vec_t;

    vec_t vecs[12];

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic do_op(input int idx, input vec_t v);
        int c0, n, want;
        if (!v.b2b) begin
            @(posedge clk); #1;
        end
        op = v.o; op_a = v.a; op_b = v.b; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; op_a = $urandom; op_b = $urandom; op = 2'($urandom);
        wait_done(n);
        want = v.lat;
`ifdef MULDIV_EARLY_TERM_EN
        if (!v.o[1]) want = model_lat(v.o, v.b);
`endif
        chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_lat", idx), 64'(cyc - c0), 64'(want));
        chk($sformatf("v%0d_hi", idx), 64'(hi_out), 64'(v.h));
        chk($sformatf("v%0d_lo", idx), 64'(lo_out), 64'(v.l));
        chk($sformatf("v%0d_dz", idx), 64'(div_zero), 64'(v.dz));
    endtask

    int c0, n;

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 35, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35, 1'b0};
        vecs[2]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 35, 1'b0};
        vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35, 1'b1};
        vecs[4]  = '{2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 35, 1'b0};
        vecs[5]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 35, 1'b0};
        vecs[6]  = '{2'd3, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 2,  1'b0};
        vecs[7]  = '{2'd0, 32'd0,         32'd0,         32'h0000_0000, 32'h0000_0000, 1'b0, 35, 1'b0};
        vecs[8]  = '{2'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, 2,  1'b0};
        vecs[9]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 35, 1'b1};
        vecs[10] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 35, 1'b0};
        vecs[11] = '{2'd3, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 35, 1'b0};

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) do_op(i, vecs[i]);

        // Second start while busy plus a 5-cycle freeze in the middle of RUN.
        @(posedge clk); #1;
        op = 2'd1; op_a = 32'h1234_5678; op_b = 32'hFFFF_FFFF; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc != c0 + 10) begin @(posedge clk); #1; end
        op = 2'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc != c0 + 15) begin @(posedge clk); #1; end
        clk_enable = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("frz_busy", 64'(busy), 64'd1);
        clk_enable = 1'b1;
        wait_done(n);
        chk("frz_done", 64'(done), 64'd1);
        chk("frz_lat", 64'(cyc - c0), 64'd40);
        chk("frz_hi", 64'(hi_out), 64'h1234_5677);
        chk("frz_lo", 64'(lo_out), 64'hEDCB_A988);

        // Asynchronous reset in the middle of a divide.
        @(posedge clk); #1;
        op = 2'd2; op_a = 32'h7FFF_FFFF; op_b = 32'd3; start = 1'b1; c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc != c0 + 20) begin @(posedge clk); #1; end
        chk("ar_pre_busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_done", 64'(done), 64'd0);
        chk("ar_hi", 64'(hi_out), 64'd0);
        chk("ar_lo", 64'(lo_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        do_op(12, '{2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 35, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
